// File: rtl/banked_reg_file_pc_if.sv
// Bus bundle for banked_reg_file_pc: PC control, packed read ports, write
// port and the PC outputs. The master side drives control/addresses/data,
// the slave side (the register file) returns read data and the PC.
interface banked_reg_file_pc_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 3
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic                                 pc_en;
    logic                                 pc_src;
    logic [DATA_WIDTH-1:0]                pc_target;
    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] ra;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd;
    logic                                 we;
    logic [ADDR_WIDTH-1:0]                wa;
    logic [DATA_WIDTH-1:0]                wd;
    logic [DATA_WIDTH-1:0]                pc;
    logic [DATA_WIDTH-1:0]                pc_plus_step;

    modport master (
        output pc_en, pc_src, pc_target, ra, we, wa, wd,
        input  rd, pc, pc_plus_step
    );

    modport slave (
        input  pc_en, pc_src, pc_target, ra, we, wa, wd,
        output rd, pc, pc_plus_step
    );
endinterface

// File: rtl/banked_reg_file_pc.sv
// Register file with an integrated program counter. The top register index
// is an alias that reads PC+PC_OFFSET and cannot be written; the PC changes
// only through pc_en/pc_src/pc_target. Reads are combinational, with an
// optional same-cycle bypass of the write port.
module banked_reg_file_pc #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 3,
    parameter int PC_OFFSET      = 8,
    parameter int PC_STEP        = 4,
    parameter int RESET_PC       = 0,
    parameter int BYPASS         = 1
) (
    input logic                 clk,
    input logic                 reset,
    banked_reg_file_pc_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] PC_IDX     = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] STEP_VAL   = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] OFFSET_VAL = DATA_WIDTH'(PC_OFFSET);
    localparam logic [DATA_WIDTH-1:0] RESET_VAL  = DATA_WIDTH'(RESET_PC);

    // The top entry exists only to keep indexing in range; it is never
    // written and is always shadowed by the PC alias on reads.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_alias;
    logic                  write_hit;
    logic [ADDR_WIDTH-1:0] ra_arr [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_arr [NUM_READ_PORTS];

    assign write_hit        = bus.we && (bus.wa != PC_IDX);
    assign pc_alias         = pc_q + OFFSET_VAL;
    assign bus.pc           = pc_q;
    assign bus.pc_plus_step = pc_q + STEP_VAL;

    // General registers: cleared on reset, written whenever we is set,
    // independent of any PC stall; writes aimed at the alias are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Program counter: hold on stall, otherwise redirect or step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else if (bus.pc_en) begin
            if (bus.pc_src) begin
                pc_q <= bus.pc_target;
            end else begin
                pc_q <= pc_q + STEP_VAL;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        assign ra_arr[p] = bus.ra[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: PC alias first, then same-cycle bypass, then storage.
        always_comb begin
            rd_arr[p] = regs[ra_arr[p]];
            if (ra_arr[p] == PC_IDX) begin
                rd_arr[p] = pc_alias;
            end else if ((BYPASS != 0) && write_hit && (bus.wa == ra_arr[p])) begin
                rd_arr[p] = bus.wd;
            end
        end

        assign bus.rd[p*DATA_WIDTH +: DATA_WIDTH] = rd_arr[p];
    end

endmodule

// File: tb/tb_banked_reg_file_pc.sv
// Directed bench for banked_reg_file_pc: one DUT with bypass, one without,
// both driven by the same stimulus so same-cycle read behaviour can be compared.
module tb_banked_reg_file_pc;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    banked_reg_file_pc_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3)) bus_b ();
    banked_reg_file_pc_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3)) bus_n ();

    banked_reg_file_pc #(.BYPASS(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    banked_reg_file_pc #(.BYPASS(0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    assign bus_n.pc_en     = bus_b.pc_en;
    assign bus_n.pc_src    = bus_b.pc_src;
    assign bus_n.pc_target = bus_b.pc_target;
    assign bus_n.ra        = bus_b.ra;
    assign bus_n.we        = bus_b.we;
    assign bus_n.wa        = bus_b.wa;
    assign bus_n.wd        = bus_b.wd;

    logic [31:0] rd_b0, rd_b1, rd_b2, rd_n0, rd_n1;
    assign rd_b0 = bus_b.rd[31:0];
    assign rd_b1 = bus_b.rd[63:32];
    assign rd_b2 = bus_b.rd[95:64];
    assign rd_n0 = bus_n.rd[31:0];
    assign rd_n1 = bus_n.rd[63:32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic pc_en, input logic pc_src, input logic [31:0] target,
                                  input logic we, input logic [3:0] wa, input logic [31:0] wd);
        bus_b.pc_en     = pc_en;
        bus_b.pc_src    = pc_src;
        bus_b.pc_target = target;
        bus_b.we        = we;
        bus_b.wa        = wa;
        bus_b.wd        = wd;
    endtask

    task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus_b.ra = {a2, a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        set_ra(4'd15, 4'd0, 4'd14);
        #12;
        reset = 1'b0;
        #1;
        check_output("reset_pc", bus_b.pc, 32'h0);
        check_output("reset_pc_plus_step", bus_b.pc_plus_step, 32'h4);
        check_output("reset_alias", rd_b0, 32'h8);
        check_output("reset_r0", rd_b1, 32'h0);
        check_output("reset_r14", rd_b2, 32'h0);
        for (int i = 0; i < 15; i++) begin
            set_ra(4'(i), 4'd0, 4'd0);
            #1;
            check_output($sformatf("reset_r%0d", i), rd_b0, 32'h0);
        end

        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd1, 32'd15);
        set_ra(4'd1, 4'd1, 4'd1);
        #1;
        check_output("bypass_same_cycle", rd_b0, 32'd15);
        check_output("nobypass_same_cycle", rd_n0, 32'd0);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        #1;
        check_output("r1_port0", rd_b0, 32'd15);
        check_output("r1_port1", rd_b1, 32'd15);
        check_output("r1_port2", rd_b2, 32'd15);
        check_output("nobypass_r1_next", rd_n0, 32'd15);
        check_output("stall_pc_hold", bus_b.pc, 32'h0);

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd11, 32'd32);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        set_ra(4'd11, 4'd1, 4'd0);
        #1;
        check_output("store_r11", rd_b0, 32'd32);
        check_output("store_r1", rd_b1, 32'd15);
        check_output("store_r11_nobypass", rd_n0, 32'd32);

        apply_stimulus(1'b1, 1'b1, 32'd128, 1'b0, 4'd0, 32'h0);
        next_cycle();
        check_output("redirect_pc", bus_b.pc, 32'd128);
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        set_ra(4'd15, 4'd2, 4'd0);
        #1;
        check_output("redirect_alias", rd_b0, 32'd136);
        check_output("redirect_pc_plus_step", bus_b.pc_plus_step, 32'd132);
        next_cycle();
        check_output("step1_pc", bus_b.pc, 32'd132);
        next_cycle();
        check_output("step2_pc", bus_b.pc, 32'd136);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd7);
        next_cycle();
        next_cycle();
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        #1;
        check_output("stall_pc", bus_b.pc, 32'd136);
        check_output("stall_write_r2", rd_b1, 32'd7);
        check_output("stall_pc_nobypass", bus_n.pc, 32'd136);

        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 4'd15, 32'h0000DEAD);
        set_ra(4'd15, 4'd14, 4'd0);
        #1;
        check_output("alias_write_same_cycle", rd_b0, 32'd144);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        #1;
        check_output("alias_write_pc", bus_b.pc, 32'd136);
        check_output("alias_write_alias", rd_b0, 32'd144);
        check_output("alias_write_r14", rd_b1, 32'd0);
        check_output("alias_write_alias_nobypass", rd_n0, 32'd144);

        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'h0);
        next_cycle();
        check_output("wrap_load_pc", bus_b.pc, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        #1;
        check_output("wrap_alias", rd_b0, 32'h0000_0004);
        check_output("wrap_pc_plus_step", bus_b.pc_plus_step, 32'h0);
        next_cycle();
        check_output("wrap_pc", bus_b.pc, 32'h0);

        apply_stimulus(1'b1, 1'b1, 32'h40, 1'b0, 4'd0, 32'h0);
        next_cycle();
        check_output("pre_reset_pc", bus_b.pc, 32'h40);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        set_ra(4'd1, 4'd3, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_pc", bus_b.pc, 32'h0);
        check_output("async_reset_r1", rd_b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 4'd3, 32'd99);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'h0);
        #1;
        check_output("reset_discards_write", rd_b1, 32'h0);
        check_output("reset_discards_write_nobypass", rd_n1, 32'h0);
        #2;
        reset = 1'b0;
        next_cycle();
        check_output("post_reset_pc", bus_b.pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
